psum_accum_writeback: RTL and testbench

//  Read-modify-write stage wrapped around the partial-sum buffer FIFO; sits between the systolic array column output and that buffer.

---
 rtl/psum_accum_writeback_pkg.sv | 6 +
 rtl/psum_accum_writeback_add.sv | 17 +
 rtl/psum_accum_writeback.sv | 101 ++++++++++
 tb/tb_psum_accum_writeback.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_writeback_pkg.sv
// psum_accum_writeback_pkg: shared sizes and FSM states for the partial-sum writeback stage
package psum_accum_writeback_pkg;
  localparam int PSUM_DWIDTH = 16;
  localparam int PSUM_TILE_LEN = 8;
  typedef enum logic [2:0] {PRIME, IDLE, FIRST, ACCUM, LAST, DRAIN} psum_state_e;
endpackage

// File: rtl/psum_accum_writeback_add.sv
// psum_add: two's-complement adder with optional clamp to the signed DWIDTH range
module psum_add #(
  parameter int DWIDTH = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] sum
);
  logic [DWIDTH:0] wide;
  logic ovf;
  always_comb begin
    wide = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
    ovf = wide[DWIDTH] ^ wide[DWIDTH-1];
    sum = (SATURATE && ovf) ? {wide[DWIDTH], {(DWIDTH-1){!wide[DWIDTH]}}} : wide[DWIDTH-1:0];
  end
endmodule

// File: rtl/psum_accum_writeback.sv
// psum_accum_writeback: read-modify-write accumulation of K tiles through the partial-sum buffer
module psum_accum_writeback
  import psum_accum_writeback_pkg::*;
#(
  parameter int DWIDTH = PSUM_DWIDTH,
  parameter int TILE_LEN = PSUM_TILE_LEN,
  parameter int KW = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_tiles,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              buf_wr_en,
  output logic [DWIDTH-1:0] buf_din,
  input  logic              buf_full,
  output logic              buf_rd_en,
  input  logic [DWIDTH-1:0] buf_dout,
  input  logic              buf_empty,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready
);
  localparam int WW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  psum_state_e state;
  logic primed;
  logic [KW-1:0] k_reg, tile_cnt;
  logic [WW-1:0] word_cnt;
  logic [DWIDTH-1:0] sum;
  logic accept, last_word, k_one, prime_rd;
  psum_add #(.DWIDTH(DWIDTH), .SATURATE(SATURATE)) u_add (.a(buf_dout), .b(in_data), .sum(sum));
  // the buffer swallows its first pop after reset, so PRIME spends one on an empty buffer
  always_comb begin
    k_one = k_reg == KW'(1);
    in_ready = state == FIRST ? !buf_full :
               state == ACCUM ? !buf_empty && !buf_full :
               state == LAST  ? (k_one || !buf_empty) && (!out_valid || out_ready) : 1'b0;
    accept = in_valid && in_ready;
    last_word = word_cnt == WW'(TILE_LEN - 1);
    prime_rd = state == PRIME && !primed && !rst;
    buf_wr_en = accept && (state == FIRST || state == ACCUM);
    buf_rd_en = prime_rd || (accept && (state == ACCUM || (state == LAST && !k_one)));
    buf_din = state == FIRST ? in_data : sum;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
      primed <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      k_reg <= '0;
      tile_cnt <= '0;
      word_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept && state == LAST) begin
        out_valid <= 1'b1;
        out_data <= k_one ? in_data : sum;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (last_word) tile_cnt <= tile_cnt + 1'b1;
      end
      case (state)
        PRIME: begin
          primed <= 1'b1;
          state <= IDLE;
        end
        IDLE: if (start) begin
          if (k_tiles == '0) begin
            done <= 1'b1;
          end else begin
            k_reg <= k_tiles;
            tile_cnt <= '0;
            word_cnt <= '0;
            busy <= 1'b1;
            state <= k_tiles == KW'(1) ? LAST : FIRST;
          end
        end
        FIRST: if (accept && last_word) state <= k_reg == KW'(2) ? LAST : ACCUM;
        ACCUM: if (accept && last_word && tile_cnt == k_reg - KW'(2)) state <= LAST;
        LAST: if (accept && last_word) state <= DRAIN;
        DRAIN: if (out_valid && out_ready) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= PRIME;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accum_writeback.sv
// tb_psum_accum_writeback: random jobs against a per-word tile-sum model and a FIFO buffer model
module tb_psum_accum_writeback;
  localparam int DW = 16;
  localparam int TL = 8;
  localparam int KW = 8;
  localparam int DEPTH = TL + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [KW-1:0] k_tiles = '0;
  logic busy, done, in_ready, buf_wr_en, buf_rd_en, buf_full, buf_empty, out_valid;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] buf_din, buf_dout, out_data;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] jt [8][TL];
  logic [DW-1:0] sa, sb, ss;
  int head = 0, cnt = 0, proto_err = 0, rd_pulses = 0, wr_pulses = 0, done_cnt = 0;
  bit skip_rd = 1'b1;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  psum_accum_writeback #(.DWIDTH(DW), .TILE_LEN(TL), .KW(KW), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .k_tiles(k_tiles), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .buf_wr_en(buf_wr_en), .buf_din(buf_din), .buf_full(buf_full),
    .buf_rd_en(buf_rd_en), .buf_dout(buf_dout), .buf_empty(buf_empty),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );
  psum_add #(.DWIDTH(DW), .SATURATE(1'b1)) u_sat (.a(sa), .b(sb), .sum(ss));
  assign buf_empty = cnt == 0;
  assign buf_full = cnt >= DEPTH;
  assign buf_dout = mem[head];
  // buffer model: ignores first pop after reset, flags illegal strobes
  always @(posedge clk) begin
    int h, c, pe;
    h = head;
    c = cnt;
    pe = 0;
    if (rst) begin
      head <= 0;
      cnt <= 0;
      skip_rd <= 1'b1;
      rd_pulses <= 0;
    end else begin
      if ((buf_wr_en || (buf_rd_en && !skip_rd)) && !(in_valid && in_ready)) pe++;
      if (buf_wr_en && cnt >= DEPTH) pe++;
      if (buf_rd_en) begin
        rd_pulses <= rd_pulses + 1;
        if (skip_rd) skip_rd <= 1'b0;
        else if (c == 0) pe++;
        else begin
          h = (h + 1) % DEPTH;
          c--;
        end
      end
      if (buf_wr_en) begin
        wr_pulses <= wr_pulses + 1;
        if (c < DEPTH) begin
          mem[(h + c) % DEPTH] <= buf_din;
          c++;
        end
      end
      head <= h;
      cnt <= c;
      proto_err <= proto_err + pe;
      if (done) done_cnt <= done_cnt + 1;
    end
  end
  function automatic logic [DW-1:0] sat_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = $signed(a);
    s += $signed(b);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[DW-1:0];
  endfunction
  task automatic fill_random;
    for (int t = 0; t < 8; t++) for (int i = 0; i < TL; i++) jt[t][i] = DW'($urandom);
  endtask
  task automatic run_job(input int k, input int stall, input bit gappy, input bit poke);
    logic [DW-1:0] exp_q [TL];
    logic [DW-1:0] got [$];
    logic [DW-1:0] held;
    int d0, r0, w0, maxc, n, bd, bc;
    bit stalled;
    for (int i = 0; i < TL; i++) begin
      exp_q[i] = '0;
      for (int t = 0; t < k; t++) exp_q[i] += jt[t][i];
    end
    d0 = done_cnt; r0 = rd_pulses; w0 = wr_pulses;
    maxc = 0; n = 0; bd = 0; bc = 0; stalled = 1'b0;
    @(negedge clk);
    k_tiles = KW'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_start k=%0d: got %b want 1", k, busy); end
    fork
      begin
        while (n < k * TL && bd < 3000) begin
          @(negedge clk);
          bd++;
          start = poke && n == TL / 2;
          in_valid = !gappy || $urandom_range(0, 2) != 0;
          in_data = jt[n / TL][n % TL];
          #2;
          if (in_valid && in_ready) n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
      end
      begin
        while (got.size() < TL && bc < 3000) begin
          @(negedge clk);
          bc++;
          if (cnt > maxc) maxc = cnt;
          if (stall > 0 && !stalled && out_valid) begin
            held = out_data;
            stalled = 1'b1;
            for (int s = 0; s < stall; s++) begin
              out_ready = 1'b0;
              #1;
              vectors++;
              if (out_data !== held || in_ready !== 1'b0 || buf_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d: data=%h in_ready=%b rd=%b want data=%h in_ready=0 rd=0", s, out_data, in_ready, buf_rd_en, held);
              end
              @(negedge clk);
            end
          end
          out_ready = stall > 0 || $urandom_range(0, 3) != 0;
          #1;
          if (out_valid && out_ready) got.push_back(out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL done_pulse k=%0d: done=%b busy=%b want done=1 busy=0", k, done, busy); end
        @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL done_width k=%0d: done=%b want 0", k, done); end
      end
    join
    vectors++;
    if (n != k * TL || got.size() != TL) begin miscompares++; $display("FAIL job_timeout k=%0d: accepted=%0d outputs=%0d want %0d/%0d", k, n, got.size(), k * TL, TL); end
    for (int i = 0; i < TL && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin miscompares++; $display("FAIL sum k=%0d word=%0d: got %h want %h", k, i, got[i], exp_q[i]); end
    end
    vectors++;
    if (cnt != 0 || maxc != (k > 1 ? TL : 0)) begin miscompares++; $display("FAIL buf_level k=%0d: end=%0d max=%0d want end=0 max=%0d", k, cnt, maxc, k > 1 ? TL : 0); end
    vectors++;
    if (rd_pulses - r0 != (k - 1) * TL || wr_pulses - w0 != (k - 1) * TL) begin
      miscompares++;
      $display("FAIL buf_traffic k=%0d: pops=%0d pushes=%0d want %0d each", k, rd_pulses - r0, wr_pulses - w0, (k - 1) * TL);
    end
    vectors++;
    if (done_cnt - d0 != 1 || proto_err != 0) begin miscompares++; $display("FAIL job_protocol k=%0d: done_pulses=%0d strobe_errs=%0d want 1/0", k, done_cnt - d0, proto_err); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({busy, done, out_valid, buf_wr_en, buf_rd_en, in_ready} !== 6'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b ov=%b wr=%b rd=%b rdy=%b data=%h want all 0", busy, done, out_valid, buf_wr_en, buf_rd_en, in_ready, out_data);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (buf_rd_en !== 1'b1) begin miscompares++; $display("FAIL prime_pulse: rd=%b want 1", buf_rd_en); end
    @(negedge clk);
    #1;
    vectors++;
    if (buf_rd_en !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL prime_end: rd=%b rdy=%b want 0/0", buf_rd_en, in_ready); end
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_pulses != 1 || cnt != 0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_prime: pops=%0d level=%0d busy=%b done=%b want 1/0/0/0", rd_pulses, cnt, busy, done);
    end
  endtask
  task automatic test_zero_k;
    int d0, r0, w0;
    d0 = done_cnt; r0 = rd_pulses; w0 = wr_pulses;
    @(negedge clk);
    k_tiles = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_k_done: done=%b busy=%b want 1/0", done, busy); end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || done_cnt - d0 != 1 || rd_pulses != r0 || wr_pulses != w0) begin
      miscompares++;
      $display("FAIL zero_k_after: done=%b pulses=%0d pops=%0d pushes=%0d want 0/1/0/0", done, done_cnt - d0, rd_pulses - r0, wr_pulses - w0);
    end
  endtask
  task automatic test_single_tile;
    for (int i = 0; i < TL; i++) jt[0][i] = DW'(i + 1);
    run_job(1, 0, 1'b1, 1'b0);
  endtask
  task automatic test_three_tiles;
    for (int t = 0; t < 3; t++) for (int i = 0; i < TL; i++) jt[t][i] = 16'd5;
    run_job(3, 0, 1'b0, 1'b0);
  endtask
  task automatic test_saturate;
    logic [DW-1:0] want;
    for (int v = 0; v < 18; v++) begin
      sa = v == 0 ? 16'h7FF0 : v == 1 ? 16'h8000 : DW'($urandom);
      sb = v == 0 ? 16'h0020 : v == 1 ? 16'hFFFF : DW'($urandom);
      #1;
      want = v == 0 ? 16'h7FFF : v == 1 ? 16'h8000 : sat_ref(sa, sb);
      vectors++;
      if (ss !== want) begin miscompares++; $display("FAIL saturate %h+%h: got %h want %h", sa, sb, ss, want); end
    end
    for (int i = 0; i < TL; i++) begin
      jt[0][i] = 16'h7FF0;
      jt[1][i] = 16'h0020;
    end
    run_job(2, 0, 1'b0, 1'b0);
  endtask
  task automatic test_stall;
    fill_random();
    run_job(2, 5, 1'b0, 1'b0);
  endtask
  task automatic test_mid_reset;
    int n, bd, d0;
    fill_random();
    d0 = done_cnt; n = 0; bd = 0;
    @(negedge clk);
    k_tiles = KW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < TL + 3 && bd < 200) begin
      in_valid = 1'b1;
      in_data = DW'($urandom);
      #2;
      if (in_ready) n++;
      @(negedge clk);
      bd++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (n != TL + 3 || busy !== 1'b0 || done !== 1'b0 || buf_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_abort: accepted=%0d busy=%b done=%b rd=%b want %0d/0/0/0", n, busy, done, buf_rd_en, TL + 3);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (buf_rd_en !== 1'b1 || cnt != 0) begin miscompares++; $display("FAIL mid_reset_prime: rd=%b level=%0d want 1/0", buf_rd_en, cnt); end
    @(negedge clk);
    #1;
    vectors++;
    if (buf_rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_reset_prime_end: rd=%b want 0", buf_rd_en); end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt != d0) begin miscompares++; $display("FAIL mid_reset_no_done: pulses=%0d want 0", done_cnt - d0); end
    fill_random();
    run_job(2, 0, 1'b1, 1'b0);
  endtask
  task automatic test_back_to_back;
    for (int j = 0; j < 5; j++) begin
      fill_random();
      run_job(int'($urandom_range(1, 5)), 0, j[0], j == 1);
    end
  endtask
  initial begin
    test_reset();
    test_zero_k();
    test_single_tile();
    test_three_tiles();
    test_saturate();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
